// File: rtl/sparse_pe_pkg.sv
// Shared constants, derived index widths and types for the sparse convolution PE.
package sparse_pe_pkg;

  localparam int IA_ROW             = 4;
  localparam int IA_COL             = 4;
  localparam int IA_CHANNEL         = 4;
  localparam int IA_DATA_BITWIDTH   = 16;
  localparam int IA_C_BITWIDTH      = 5;
  localparam int W_C_LENGTH         = 12;
  localparam int W_DATA_BITWIDTH    = 16;
  localparam int W_C_BITWIDTH       = 5;
  localparam int W_R_LENGTH         = 8;
  localparam int W_POS_PTR_BITWIDTH = 11;
  localparam int W_R_BITWIDTH       = 2;
  localparam int W_K_BITWIDTH       = 5;

  localparam int IA_H_W    = $clog2(IA_ROW) + 1;
  localparam int IA_W_W    = $clog2(IA_COL) + 1;
  localparam int IA_LEN_W  = $clog2(IA_CHANNEL) + 1;
  localparam int W_LEN_W   = $clog2(W_C_LENGTH) + 1;
  localparam int W_E_W     = $clog2(W_C_LENGTH);
  localparam int W_G_W     = $clog2(W_R_LENGTH);
  localparam int OUT_N     = 3 * IA_CHANNEL;
  localparam int OUT_IDX_W = $clog2(OUT_N);
  localparam int PROD_W    = IA_DATA_BITWIDTH + W_DATA_BITWIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

  typedef struct packed {
    logic [IA_H_W-1:0]   ia_h;
    logic [IA_W_W-1:0]   ia_w;
    logic [IA_LEN_W-1:0] ia_iters;
    logic [IA_LEN_W-1:0] ia_len;
    logic [1:0]          w_s;
    logic [W_LEN_W-1:0]  w_iters;
    logic [W_LEN_W-1:0]  w_len;
  } cfg_t;

  // Flattened partial-sum slot for filter row r, output channel k.
  function automatic logic [OUT_IDX_W-1:0] out_index(input logic [W_R_BITWIDTH-1:0] r,
                                                     input logic [W_K_BITWIDTH-1:0] k);
    return OUT_IDX_W'(r) * OUT_IDX_W'(IA_CHANNEL) + OUT_IDX_W'(k);
  endfunction

endpackage

// File: rtl/sparse_conv_pe_if.sv
// Bundle of the PE's start/operand inputs and finish/partial-sum outputs.
interface sparse_conv_pe_if;
  import sparse_pe_pkg::*;

  logic                                 i_start;
  logic [IA_H_W-1:0]                    i_ia_h;
  logic [IA_W_W-1:0]                    i_ia_w;
  logic signed [IA_DATA_BITWIDTH-1:0]   i_ia_data  [IA_CHANNEL];
  logic [IA_C_BITWIDTH-1:0]             i_ia_c_idx [IA_CHANNEL];
  logic [IA_LEN_W-1:0]                  i_ia_iters;
  logic [IA_LEN_W-1:0]                  i_ia_len;
  logic [1:0]                           i_w_s;
  logic signed [W_DATA_BITWIDTH-1:0]    i_w_data   [W_C_LENGTH];
  logic [W_C_BITWIDTH-1:0]              i_w_c_idx  [W_C_LENGTH];
  logic [W_POS_PTR_BITWIDTH-1:0]        i_pos_ptr  [W_R_LENGTH];
  logic [W_R_BITWIDTH-1:0]              i_r_idx    [W_R_LENGTH];
  logic [W_K_BITWIDTH-1:0]              i_k_idx    [W_R_LENGTH];
  logic [W_LEN_W-1:0]                   i_w_iters;
  logic [W_LEN_W-1:0]                   i_w_len;
  logic                                 o_finish;
  logic signed [IA_DATA_BITWIDTH-1:0]   o_output_feature [OUT_N];

  modport master (
    output i_start, i_ia_h, i_ia_w, i_ia_data, i_ia_c_idx, i_ia_iters, i_ia_len,
           i_w_s, i_w_data, i_w_c_idx, i_pos_ptr, i_r_idx, i_k_idx, i_w_iters, i_w_len,
    input  o_finish, o_output_feature
  );

  modport slave (
    input  i_start, i_ia_h, i_ia_w, i_ia_data, i_ia_c_idx, i_ia_iters, i_ia_len,
           i_w_s, i_w_data, i_w_c_idx, i_pos_ptr, i_r_idx, i_k_idx, i_w_iters, i_w_len,
    output o_finish, o_output_feature
  );

endinterface

// File: rtl/sparse_pe_match.sv
// Combinational channel-match MAC: one weight entry against every valid IA entry.
module sparse_pe_match
  import sparse_pe_pkg::*;
(
  input  logic signed [W_DATA_BITWIDTH-1:0]  w_data,
  input  logic [W_C_BITWIDTH-1:0]            w_c_idx,
  input  logic signed [IA_DATA_BITWIDTH-1:0] ia_data  [IA_CHANNEL],
  input  logic [IA_C_BITWIDTH-1:0]           ia_c_idx [IA_CHANNEL],
  input  logic [IA_LEN_W-1:0]                ia_len,
  output logic signed [PROD_W-1:0]           match_sum
);

  logic [PROD_W-1:0] term [IA_CHANNEL];

  generate
    for (genvar gi = 0; gi < IA_CHANNEL; gi++) begin : g_lane
      logic                     hit;
      logic signed [PROD_W-1:0] prod;
      assign hit     = (IA_LEN_W'(gi) < ia_len) && (ia_c_idx[gi] == w_c_idx);
      assign prod    = w_data * ia_data[gi];
      assign term[gi] = hit ? prod : '0;
    end
  endgenerate

  // Duplicate channel indices in the fibre all contribute.
  always_comb begin
    match_sum = '0;
    for (int j = 0; j < IA_CHANNEL; j++) begin
      match_sum = match_sum + $signed(term[j]);
    end
  end

endmodule

// File: rtl/sparse_conv_pe.sv
// Sparse CNN processing element: walks a CSR-like weight bundle one entry per
// cycle and accumulates channel-matched products into a 3 x IA_CHANNEL array.
module sparse_conv_pe
  import sparse_pe_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  sparse_conv_pe_if.slave   pe
);

  state_e                             state_q, state_d;
  logic [W_E_W-1:0]                   e_q, e_d;
  logic [W_G_W-1:0]                   g_q, g_d;
  logic                               finish_q, finish_d;
  cfg_t                               cfg_q, cfg_d;
  logic signed [IA_DATA_BITWIDTH-1:0] out_q [OUT_N];
  logic signed [IA_DATA_BITWIDTH-1:0] out_d [OUT_N];

  logic [W_G_W-1:0]          g_inc;
  logic [W_G_W-1:0]          g_eff;
  logic [OUT_IDX_W-1:0]      acc_idx;
  logic signed [PROD_W-1:0]  match_sum;

  sparse_pe_match u_match (
    .w_data    (pe.i_w_data[e_q]),
    .w_c_idx   (pe.i_w_c_idx[e_q]),
    .ia_data   (pe.i_ia_data),
    .ia_c_idx  (pe.i_ia_c_idx),
    .ia_len    (cfg_q.ia_len),
    .match_sum (match_sum)
  );

  // The group pointer advances at most one group per entry.
  always_comb begin
    g_inc = g_q + W_G_W'(1);
    g_eff = g_q;
    if ((g_q < W_G_W'(W_R_LENGTH - 1)) &&
        (W_POS_PTR_BITWIDTH'(e_q) == pe.i_pos_ptr[g_inc])) begin
      g_eff = g_inc;
    end
    acc_idx = out_index(pe.i_r_idx[g_eff], pe.i_k_idx[g_eff]);
  end

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    g_d      = g_q;
    cfg_d    = cfg_q;
    finish_d = 1'b0;
    out_d    = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pe.i_start) begin
          for (int i = 0; i < OUT_N; i++) out_d[i] = '0;
          e_d   = '0;
          g_d   = '0;
          cfg_d = '{ia_h: pe.i_ia_h, ia_w: pe.i_ia_w, ia_iters: pe.i_ia_iters,
                    ia_len: pe.i_ia_len, w_s: pe.i_w_s, w_iters: pe.i_w_iters,
                    w_len: pe.i_w_len};
          state_d = (pe.i_w_len == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        g_d = g_eff;
        if (acc_idx < OUT_IDX_W'(OUT_N)) begin
          out_d[acc_idx] = out_q[acc_idx] + match_sum[IA_DATA_BITWIDTH-1:0];
        end
        e_d = e_q + W_E_W'(1);
        if (e_q == W_E_W'(cfg_q.w_len - W_LEN_W'(1))) state_d = ST_DONE;
      end
      ST_DONE: begin
        finish_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      e_q      <= '0;
      g_q      <= '0;
      cfg_q    <= '0;
      finish_q <= 1'b0;
      for (int i = 0; i < OUT_N; i++) out_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      g_q      <= g_d;
      cfg_q    <= cfg_d;
      finish_q <= finish_d;
      out_q    <= out_d;
    end
  end

  assign pe.o_finish         = finish_q;
  assign pe.o_output_feature = out_q;

endmodule

// File: tb/tb_sparse_conv_pe.sv
// Scoreboard bench for sparse_conv_pe: each start pushes the modelled result,
// each finish pulse pops and compares latency and all partial sums.
module tb_sparse_conv_pe;
  import sparse_pe_pkg::*;

  typedef struct packed {
    logic [31:0]                               fin_cyc;
    logic [31:0]                               run_id;
    logic [OUT_N-1:0][IA_DATA_BITWIDTH-1:0]    out;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_conv_pe_if pe_if();
  sparse_conv_pe dut (.i_clk(clk), .i_rst_n(rst_n), .pe(pe_if));

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  int ia_d[IA_CHANNEL];
  int ia_c[IA_CHANNEL];
  int ia_len;
  int w_d[W_C_LENGTH];
  int w_c[W_C_LENGTH];
  int ptr[W_R_LENGTH];
  int r_i[W_R_LENGTH];
  int k_i[W_R_LENGTH];
  int w_len;

  int zeros[OUT_N]    = '{default: 0};
  int base_exp[OUT_N] = '{0, 4, 4, 0, 0, 25, 9, 0, 34, 36, 0, 0};
  int ia2_exp[OUT_N]  = '{0, 4, 4, 0, 0, 0, 9, 0, 9, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [IA_DATA_BITWIDTH-1:0] v);
    return int'(signed'(v));
  endfunction

  task automatic check_outs(input string tag, input int exp[OUT_N]);
    for (int i = 0; i < OUT_N; i++)
      check_val($sformatf("%s_out%0d", tag, i), sx(pe_if.o_output_feature[i]), exp[i]);
  endtask

  task automatic apply();
    pe_if.i_ia_h     = IA_H_W'(1);
    pe_if.i_ia_w     = IA_W_W'(2);
    pe_if.i_w_s      = 2'd1;
    pe_if.i_ia_len   = IA_LEN_W'(ia_len);
    pe_if.i_ia_iters = IA_LEN_W'(ia_len);
    pe_if.i_w_len    = W_LEN_W'(w_len);
    pe_if.i_w_iters  = W_LEN_W'(w_len);
    for (int j = 0; j < IA_CHANNEL; j++) begin
      pe_if.i_ia_data[j]  = IA_DATA_BITWIDTH'(ia_d[j]);
      pe_if.i_ia_c_idx[j] = IA_C_BITWIDTH'(ia_c[j]);
    end
    for (int e = 0; e < W_C_LENGTH; e++) begin
      pe_if.i_w_data[e]  = W_DATA_BITWIDTH'(w_d[e]);
      pe_if.i_w_c_idx[e] = W_C_BITWIDTH'(w_c[e]);
    end
    for (int g = 0; g < W_R_LENGTH; g++) begin
      pe_if.i_pos_ptr[g] = W_POS_PTR_BITWIDTH'(ptr[g]);
      pe_if.i_r_idx[g]   = W_R_BITWIDTH'(r_i[g]);
      pe_if.i_k_idx[g]   = W_K_BITWIDTH'(k_i[g]);
    end
  endtask

  task automatic load_base();
    ia_d = '{2, 3, 5, 6};
    ia_c = '{2, 3, 5, 6};
    ia_len = 4;
    w_d = '{0, 1, 3, 5, 2, 5, 6, 1, 2, 3, 4, 7};
    w_c = '{0, 1, 3, 5, 2, 5, 6, 1, 2, 3, 4, 7};
    ptr = '{0, 1, 4, 5, 6, 7, 9, 11};
    r_i = '{0, 2, 0, 1, 2, 0, 1, 2};
    k_i = '{0, 0, 1, 1, 1, 2, 2, 2};
    w_len = 12;
  endtask

  task automatic load_neg();
    ia_d = '{-3, 300, 0, 0};
    ia_c = '{1, 2, 0, 0};
    ia_len = 2;
    w_d = '{5, 300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    w_c = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ptr = '{0, 1, 2, 2, 2, 2, 2, 2};
    r_i = '{0, 1, 0, 0, 0, 0, 0, 0};
    k_i = '{3, 0, 0, 0, 0, 0, 0, 0};
    w_len = 2;
  endtask

  task automatic load_rand();
    ia_len = int'($urandom_range(0, IA_CHANNEL));
    for (int j = 0; j < IA_CHANNEL; j++) begin
      ia_d[j] = int'($urandom_range(0, 600)) - 300;
      ia_c[j] = int'($urandom_range(0, 7));
    end
    w_len = int'($urandom_range(1, W_C_LENGTH));
    for (int e = 0; e < W_C_LENGTH; e++) begin
      w_d[e] = int'($urandom_range(0, 600)) - 300;
      w_c[e] = int'($urandom_range(0, 7));
    end
    ptr[0] = 0;
    for (int g = 0; g < W_R_LENGTH; g++) begin
      if (g > 0) ptr[g] = ptr[g-1] + int'($urandom_range(0, 2));
      r_i[g] = int'($urandom_range(0, 2));
      k_i[g] = int'($urandom_range(0, IA_CHANNEL - 1));
    end
  endtask

  // Reference: walk entries, step the group when the entry hits the next pointer.
  function automatic exp_t model();
    exp_t res;
    int   acc[OUT_N];
    int   g;
    int   s;
    int   idx;
    logic [31:0] a;
    res = '0;
    g = 0;
    for (int o = 0; o < OUT_N; o++) acc[o] = 0;
    for (int e = 0; e < w_len; e++) begin
      if (g < W_R_LENGTH - 1 && e == ptr[g+1]) g = g + 1;
      s = 0;
      for (int j = 0; j < ia_len; j++)
        if (ia_c[j] == w_c[e]) s = s + w_d[e] * ia_d[j];
      idx = r_i[g] * IA_CHANNEL + k_i[g];
      if (idx < OUT_N) acc[idx] = acc[idx] + s;
    end
    for (int o = 0; o < OUT_N; o++) begin
      a = acc[o];
      res.out[o] = a[IA_DATA_BITWIDTH-1:0];
    end
    return res;
  endfunction

  task automatic run_start(input bit push);
    exp_t e;
    @(negedge clk);
    pe_if.i_start = 1'b1;
    e = model();
    @(posedge clk);
    #1;
    pe_if.i_start = 1'b0;
    if (push) begin
      run_cnt++;
      e.fin_cyc = cyc + w_len + 1;
      e.run_id  = run_cnt;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (sb_q.size() == 0) return;
    end
    check_val("finish_timeout", sb_q.size(), 0);
    sb_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && pe_if.o_finish === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_finish", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val($sformatf("run%0d_latency", mon_e.run_id), cyc, int'(mon_e.fin_cyc));
        for (int i = 0; i < OUT_N; i++)
          check_val($sformatf("run%0d_out%0d", mon_e.run_id, i),
                    sx(pe_if.o_output_feature[i]), sx(mon_e.out[i]));
        $display("run %0d finish at cycle %0d (expected %0d)", mon_e.run_id, cyc, mon_e.fin_cyc);
      end
    end
  end

  initial begin
    pe_if.i_start = 1'b0;
    load_base();
    apply();
    repeat (3) @(negedge clk);
    check_val("rst_finish", int'(pe_if.o_finish), 0);
    check_outs("rst", zeros);
    rst_n = 1'b1;

    run_start(1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    check_outs("base_hold", base_exp);

    run_start(1'b1);
    repeat (4) @(negedge clk);
    pe_if.i_start = 1'b1;
    @(negedge clk);
    pe_if.i_start = 1'b0;
    wait_done();

    run_start(1'b1);
    wait_done();
    check_outs("base_rerun", base_exp);

    ia_len = 2;
    apply();
    run_start(1'b1);
    wait_done();
    check_outs("ia2", ia2_exp);

    ia_len = 4;
    w_len = 0;
    apply();
    run_start(1'b1);
    wait_done();
    check_outs("wlen0", zeros);

    load_neg();
    apply();
    run_start(1'b1);
    wait_done();
    check_val("neg_prod", sx(pe_if.o_output_feature[3]), -15);
    check_val("wrap_prod", sx(pe_if.o_output_feature[4]), 24464);

    for (int n = 0; n < 4; n++) begin
      load_rand();
      apply();
      run_start(1'b1);
      wait_done();
    end

    load_base();
    apply();
    run_start(1'b0);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("midrst_finish", int'(pe_if.o_finish), 0);
    check_outs("midrst", zeros);
    @(negedge clk);
    rst_n = 1'b1;
    run_start(1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
